// File: rtl/elastic_buffer_skp.sv
// Single-clock RX elastic buffer with SKP-based rate compensation.
//
// Sits between the 8b/10b symbol aligner and the decoder. Writes (data_in_valid) and reads
// (read_enable) are independent strobes in the local_clock domain. When the buffer runs
// near full, repeated SKP symbols are dropped on the write side. When it runs near empty,
// an extra SKP is emitted on the read side right after a real SKP. This keeps occupancy
// centred. A lost write (overflow) or an empty read (underflow) is flagged and never
// corrupts stored data.
//
// Ports:
//   local_clock    - sole clock, rising edge
//   reset          - synchronous, active-high
//   data_in        - incoming symbol
//   data_in_valid  - write strobe
//   read_enable    - read strobe
//   data_out       - registered output symbol (holds when not refreshed)
//   data_out_valid - data_out carries a real or inserted symbol this cycle
//   occupancy      - number of stored entries, exact for 0..DEPTH
//   skp_added      - pulse: SKP inserted on the read side
//   skp_deleted    - pulse: SKP dropped on the write side
//   overflow       - pulse: write lost because the buffer was full
//   underflow      - pulse: read found the buffer empty
module elastic_buffer_skp #(
  parameter int unsigned            DATA_WIDTH     = 10,
  parameter int unsigned            DEPTH          = 16,
  parameter logic [DATA_WIDTH-1:0]  SKIP_SYMBOL    = 10'h1A1,
  parameter logic [DATA_WIDTH-1:0]  COMMA_SYMBOL   = 10'h1BC,
  parameter int unsigned            LOW_WATERMARK  = 4,
  parameter int unsigned            HIGH_WATERMARK = 12
) (
  input  logic                       local_clock,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       data_in_valid,
  input  logic                       read_enable,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       data_out_valid,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       skp_added,
  output logic                       skp_deleted,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntLow  = CntW'(LOW_WATERMARK);
  localparam logic [CntW-1:0] CntHigh = CntW'(HIGH_WATERMARK);

  // Elaboration-time sanity checks on the parameter set. Pointers wrap naturally, so DEPTH
  // has to be a power of two. A COM code equal to the SKP code would make alignment
  // symbols subject to deletion.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("elastic_buffer_skp: DEPTH must be a power of two >= 4");
  end
  if (!(LOW_WATERMARK > 0 && LOW_WATERMARK < HIGH_WATERMARK && HIGH_WATERMARK < DEPTH))
  begin : g_bad_watermarks
    $error("elastic_buffer_skp: need 0 < LOW_WATERMARK < HIGH_WATERMARK < DEPTH");
  end
  if (COMMA_SYMBOL == SKIP_SYMBOL) begin : g_bad_codes
    $error("elastic_buffer_skp: COMMA_SYMBOL must differ from SKIP_SYMBOL");
  end

  // Storage and state
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  prev_in_skp_q;   // last valid input symbol was SKP
  logic                  last_out_skp_q;  // last real symbol read out was SKP
  logic                  inserted_q;      // an SKP was already inserted after that symbol

  // Decoded per-cycle events (all based on the pre-edge occupancy)
  logic                  in_is_skp;
  logic                  buf_full, buf_empty;
  logic                  do_delete, do_store, do_overflow;
  logic                  do_insert, do_pop, do_underflow;
  logic [DATA_WIDTH-1:0] head;

  always_comb begin
    in_is_skp = (data_in == SKIP_SYMBOL);
    buf_full  = (count_q == CntFull);
    buf_empty = (count_q == '0);
    head      = mem_q[rd_ptr_q];

    // Write side: deletion beats overflow. Requiring prev_in_skp_q means the first SKP of
    // a run is always kept, so an ordered set never loses every SKP.
    do_delete   = data_in_valid && in_is_skp && prev_in_skp_q && (count_q >= CntHigh);
    do_overflow = data_in_valid && !do_delete && buf_full;
    do_store    = data_in_valid && !do_delete && !buf_full;

    // Read side: insertion beats both underflow and a normal pop.
    do_insert    = read_enable && last_out_skp_q && !inserted_q && (count_q <= CntLow);
    do_underflow = read_enable && !do_insert && buf_empty;
    do_pop       = read_enable && !do_insert && !buf_empty;

    count_d = count_q;
    unique case ({do_store, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Buffer contents are not reset; only pointer/count state defines validity.
  always_ff @(posedge local_clock) begin
    if (!reset && do_store) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge local_clock) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      prev_in_skp_q  <= 1'b0;
      last_out_skp_q <= 1'b0;
      inserted_q     <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      skp_added      <= 1'b0;
      skp_deleted    <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      count_q     <= count_d;
      skp_deleted <= do_delete;
      overflow    <= do_overflow;
      skp_added   <= do_insert;
      underflow   <= do_underflow;

      // Write path
      if (data_in_valid) begin
        prev_in_skp_q <= in_is_skp;
      end
      if (do_store) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end

      // Read path
      data_out_valid <= do_insert || do_pop;
      if (do_insert) begin
        data_out   <= SKIP_SYMBOL;
        inserted_q <= 1'b1;
      end else if (do_underflow) begin
        last_out_skp_q <= 1'b0;
      end else if (do_pop) begin
        data_out       <= head;
        rd_ptr_q       <= rd_ptr_q + PtrW'(1);
        inserted_q     <= 1'b0;
        last_out_skp_q <= (head == SKIP_SYMBOL);
      end
    end
  end

  assign occupancy = count_q;

endmodule
